// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that merges N_REQ byte-stream requesters
// onto a single UART transmit engine, one whole packet at a time.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester k on bits [8k+7:8k]
//   req_last_i   per-requester last-byte-of-packet flag
//   req_ready_o  per-requester byte accept (only the owner, only in DATA)
//   tx_start_o   one-cycle pulse starting a serial byte transmit
//   tx_data_o    byte to transmit, held from tx_start_o until tx_done_i
//   tx_done_i    end-of-stop-bit pulse from the serial engine
//   grant_o      current owner index, valid while busy_o
//   busy_o       high whenever the FSM is not idle
//   pkt_cnt_o    count of completed packets, wraps at 16 bits
module uart_tx_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter bit          HDR_EN   = 1'b1,
  parameter logic [7:0]  HDR_BASE = 8'hF0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o,
  input  logic               tx_done_i,
  output logic [2:0]         grant_o,
  output logic               busy_o,
  output logic [15:0]        pkt_cnt_o
);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        last_q, last_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Requester vectors padded to the 8-entry maximum so a 3-bit index always fits exactly.
  logic [7:0]  valid_ext;
  logic [7:0]  last_ext;
  logic [63:0] data_ext;
  logic [7:0]  ready_ext;

  assign valid_ext = 8'(req_valid_i);
  assign last_ext  = 8'(req_last_i);
  assign data_ext  = 64'(req_data_i);

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping modulo N_REQ.
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [3:0] pick_sum;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pick_sum = {1'b0, rr_ptr_q} + 4'(i);
      if (pick_sum >= 4'(N_REQ)) begin
        pick_sum = pick_sum - 4'(N_REQ);
      end
      if (!pick_found && valid_ext[pick_sum[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    last_d     = last_q;
    pkt_cnt_d  = pkt_cnt_q;
    ready_ext  = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = HDR_EN ? StHdr : StData;
        end
      end
      StHdr: begin
        tx_data_d  = HDR_BASE | {5'b0, grant_q};
        last_d     = 1'b0;
        tx_start_d = 1'b1;
        state_d    = StWait;
      end
      StData: begin
        // The grant is held until the packet's last byte, however long the owner stalls.
        ready_ext = 8'b1 << grant_q;
        if (valid_ext[grant_q]) begin
          tx_data_d  = data_ext[{grant_q, 3'b000} +: 8];
          last_d     = last_ext[grant_q];
          tx_start_d = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // A done arriving alongside the start pulse belongs to no byte of ours.
        if (tx_done_i && !tx_start_q) begin
          if (last_q) begin
            state_d   = StIdle;
            rr_ptr_d  = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
          end else begin
            state_d = StData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      tx_data_q  <= 8'hFF;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_q     <= last_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign req_ready_o = ready_ext[N_REQ-1:0];
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != StIdle);
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter. Requesters hold queues of packets; a packet-level
// model plans the expected transmit stream (headers, bytes, owners) and a serial-engine model
// answers each start with a delayed done, sometimes with an ignored same-cycle done.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [N-1:0]   valid, last, ready;
  logic [8*N-1:0] data;
  logic        tx_start, tx_done, busy;
  logic [7:0]  tx_data;
  logic [2:0]  grant;
  logic [15:0] pkt_cnt;

  // Second instance without headers, used for the counter-wrap check.
  logic [N-1:0]   v2, l2, r2;
  logic [8*N-1:0] d2;
  logic        ts2, done2, busy2;
  logic [7:0]  txd2;
  logic [2:0]  g2;
  logic [15:0] cnt2;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .HDR_EN(1'b1), .HDR_BASE(8'hF0)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready), .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_done_i(tx_done),
    .grant_o(grant), .busy_o(busy), .pkt_cnt_o(pkt_cnt)
  );

  uart_tx_arbiter #(.N_REQ(N), .HDR_EN(1'b0), .HDR_BASE(8'hF0)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_data_i(d2), .req_last_i(l2),
    .req_ready_o(r2), .tx_start_o(ts2), .tx_data_o(txd2), .tx_done_i(done2),
    .grant_o(g2), .busy_o(busy2), .pkt_cnt_o(cnt2)
  );

  typedef struct packed {
    logic       hdr;
    logic [2:0] own;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic [8:0] rq[N][$];  // bytes still to be offered by each requester {last, data}
  logic [8:0] mq[N][$];  // bytes not yet planned by the model
  exp_t       exp_q[$];
  exp_t       cur;
  int         m_ptr, m_cnt;
  int         n_tests, n_fail, n_start;
  bit         mid[N];
  bit         hs[N];
  bit         eng_busy;
  int         eng_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_byte(input int k, input logic [7:0] b, input bit is_last);
    rq[k].push_back({is_last, b});
    mq[k].push_back({is_last, b});
  endtask

  // Packet-level plan: owners in round-robin order among requesters with queued packets.
  task automatic model_plan();
    int         k;
    bit         found;
    logic [8:0] b;
    forever begin
      found = 0;
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && mq[(m_ptr + i) % N].size() > 0) begin
          found = 1;
          k = (m_ptr + i) % N;
        end
      end
      if (!found) break;
      exp_q.push_back('{hdr: 1'b1, own: 3'(k), last: 1'b0, data: 8'hF0 | 8'(k)});
      do begin
        b = mq[k].pop_front();
        exp_q.push_back('{hdr: 1'b0, own: 3'(k), last: b[8], data: b[7:0]});
      end while (!b[8]);
      m_ptr = (k + 1) % N;
    end
  endtask

  task automatic clear_bench();
    for (int k = 0; k < N; k++) begin
      rq[k].delete();
      mq[k].delete();
      mid[k] = 0;
      hs[k] = 0;
    end
    exp_q.delete();
    eng_busy = 0;
    m_ptr = 0;
    m_cnt = 0;
    valid = '0;
    tx_done = 1'b0;
  endtask

  // One cycle of bench activity, called just after a negedge.
  task automatic step();
    logic [8:0] b;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        b = rq[k].pop_front();
        mid[k] = !b[8];
      end
    end
    tx_done = 1'b0;
    if (tx_start) begin
      n_start++;
      check_eq("ready_in_wait", 32'(ready), 32'd0);
      check_eq("start_overlap", 32'(eng_busy), 32'd0);
      check_eq("exp_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check_eq("tx_data", 32'(tx_data), 32'(cur.data));
        check_eq("busy", 32'(busy), 32'd1);
        if (cur.hdr) begin
          check_eq("grant", 32'(grant), 32'(cur.own));
          check_eq("pkt_cnt_at_hdr", 32'(pkt_cnt), 32'(m_cnt));
        end
      end
      eng_busy = 1;
      eng_cnt = $urandom_range(1, 4);
      tx_done = ($urandom % 4 == 0);
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        tx_done = 1'b1;
        eng_busy = 0;
        check_eq("tx_data_hold", 32'(tx_data), 32'(cur.data));
        check_eq("grant_hold", 32'(grant), 32'(cur.own));
        if (cur.last) m_cnt++;
      end
    end else begin
      tx_done = ($urandom % 8 == 0);
    end
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        valid[k] = mid[k] ? ($urandom % 3 != 0) : 1'b1;
        data[8*k +: 8] = rq[k][0][7:0];
        last[k] = rq[k][0][8];
      end else begin
        valid[k] = 1'b0;
        data[8*k +: 8] = 8'($urandom);
        last[k] = 1'($urandom);
      end
    end
    #1;
    check_eq("ready_onehot", 32'(ready & ~(4'b1 << grant)), 32'd0);
    for (int k = 0; k < N; k++) hs[k] = valid[k] & ready[k];
  endtask

  task automatic run_all(input int budget);
    bool_loop: for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      step();
      if (exp_q.size() == 0 && !eng_busy && rq[0].size() == 0 && rq[1].size() == 0 &&
          rq[2].size() == 0 && rq[3].size() == 0) break;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      step();
    end
    check_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
    check_eq("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_start"}, 32'(tx_start), 32'd0);
    check_eq({tag, "_data"}, 32'(tx_data), 32'hFF);
    check_eq({tag, "_ready"}, 32'(ready), 32'd0);
    check_eq({tag, "_cnt"}, 32'(pkt_cnt), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_bench();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pkt2(input logic [7:0] b, input logic [15:0] exp_cnt);
    bit seen = 0;
    v2 = 4'b0001;
    d2[7:0] = b;
    l2 = 4'b0001;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ts2) seen = 1;
    end
    check_eq("dut2_start_seen", 32'(seen), 32'd1);
    check_eq("dut2_no_hdr", 32'(txd2), 32'(b));
    check_eq("dut2_grant", 32'(g2), 32'd0);
    v2 = '0;
    @(negedge clk);
    done2 = 1'b1;
    @(negedge clk);
    done2 = 1'b0;
    check_eq("dut2_cnt", 32'(cnt2), 32'(exp_cnt));
    check_eq("dut2_idle", 32'(busy2), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start0;
    n_tests = 0;
    n_fail = 0;
    n_start = 0;
    rst = 1'b1;
    data = '0;
    last = '0;
    v2 = '0;
    d2 = '0;
    l2 = '0;
    done2 = 1'b0;
    clear_bench();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check_eq("rst2_data", 32'(txd2), 32'hFF);
    rst = 1'b0;

    // Requester 2, two bytes: F2 41 42.
    add_byte(2, 8'h41, 0);
    add_byte(2, 8'h42, 1);
    model_plan();
    run_all(500);
    check_eq("single_cnt", 32'(pkt_cnt), 32'd1);

    // Pointer now at 3, so four 1-byte packets go 3,0,1,2.
    for (int k = 0; k < N; k++) add_byte(k, 8'h10 + 8'(k), 1);
    model_plan();
    run_all(500);

    // From reset, two rounds of 1-byte packets: 0,1,2,3,0,1,2,3.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) add_byte(k, 8'(8'h20 + 8'(p * 4 + k)), 1);
    model_plan();
    run_all(1000);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        int np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++) add_byte(k, 8'($urandom), i == len - 1);
        end
      end
      model_plan();
      run_all(3000);
    end

    // Reset during WAIT of the second data byte; nothing is replayed afterwards.
    do_reset();
    add_byte(1, 8'hA1, 0);
    add_byte(1, 8'hA2, 0);
    add_byte(1, 8'hA3, 1);
    model_plan();
    start0 = n_start;
    for (int c = 0; c < 300 && n_start - start0 < 3; c++) begin
      @(negedge clk);
      step();
    end
    check_eq("reach_byte2", 32'(n_start - start0), 32'd3);
    check_eq("byte2_wait", 32'(tx_data), 32'hA2);
    rst = 1'b1;
    clear_bench();
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (5) begin
      @(negedge clk);
      check_eq("no_replay", 32'({tx_start, busy}), 32'd0);
    end
    add_byte(3, 8'h5A, 1);
    model_plan();
    run_all(500);

    // Counter wrap on the header-less instance.
    @(negedge clk);
    force dut2.pkt_cnt_q = 16'hFFFE;
    repeat (2) @(negedge clk);
    release dut2.pkt_cnt_q;
    @(negedge clk);
    check_eq("dut2_preload", 32'(cnt2), 32'hFFFE);
    pkt2(8'h33, 16'hFFFF);
    pkt2(8'h34, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter HDR_EN, default 1, meaning a channel header byte is sent before each packet.
REQ-003 SHALL have parameter HDR_BASE, default 8'hF0, meaning the header byte value is HDR_BASE | requester index.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port req_valid_i  input  N_REQ  per-requester byte valid.
REQ-007 SHALL have port req_data_i  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-008 SHALL have port req_last_i  input  N_REQ  per-requester flag marking the last byte of a packet.
REQ-009 SHALL have port req_ready_o  output  N_REQ  per-requester byte accept.
REQ-010 SHALL have port tx_start_o  output  1  one-cycle pulse that starts a serial byte transmit.
REQ-011 SHALL have port tx_data_o  output  8  byte to transmit; stable from tx_start_o until tx_done_i.
REQ-012 SHALL have port tx_done_i  input  1  pulse from the serial engine at stop-bit end.
REQ-013 SHALL have port grant_o  output  3  index of the current owner; valid while busy_o=1.
REQ-014 SHALL have port busy_o  output  1  high whenever state != IDLE.
REQ-015 SHALL have port pkt_cnt_o  output  16  count of completed packets.

Function
REQ-016 SHALL implement the states IDLE, HDR, DATA and WAIT in a registered FSM.
REQ-017 IDLE: if any req_valid_i bit is set, SHALL pick the first set bit searching round-robin from pointer rr_ptr upward (modulo N_REQ).
REQ-018 On that pick, SHALL register grant_o and go to HDR if HDR_EN=1, else to DATA.
REQ-019 HDR: SHALL load tx_data_o = HDR_BASE | grant_o, clear last_r and go to WAIT.
REQ-020 DATA: req_ready_o[grant_o] SHALL be asserted combinationally; all other req_ready_o bits SHALL be 0.
REQ-021 DATA: on req_valid_i[g] & req_ready_o[g], SHALL load tx_data_o = req byte, set last_r = req_last_i[g] and go to WAIT.
REQ-022 DATA with req_valid_i[g]=0 SHALL hold indefinitely; the grant is not released mid-packet and other requesters are ignored.
REQ-023 tx_start_o SHALL be high for exactly the first cycle of each WAIT entry and low otherwise.
REQ-024 WAIT: tx_done_i SHALL be ignored in the same cycle tx_start_o is high; it is honoured from the next cycle.
REQ-025 WAIT with tx_done_i and last_r=0 SHALL go to DATA.
REQ-026 WAIT with tx_done_i and last_r=1 SHALL go to IDLE, set rr_ptr = (grant_o+1) mod N_REQ, and increment pkt_cnt_o.
REQ-027 pkt_cnt_o SHALL wrap from 16'hFFFF to 0.
REQ-028 tx_done_i outside WAIT SHALL be ignored.
REQ-029 Byte latency: a handshake in cycle t SHALL produce tx_start_o in cycle t+1.
REQ-030 Grant latency: req_valid_i rising in IDLE at cycle t SHALL give grant_o/busy_o at t+1 and tx_start_o (header) at t+2.
REQ-031 req_ready_o SHALL be all-zero in IDLE, HDR and WAIT.
REQ-032 Requester bits at index >= N_REQ SHALL NOT exist, and grant_o SHALL never exceed N_REQ-1.

Reset
REQ-033 rst_i=1 at a posedge SHALL force: state=IDLE, rr_ptr=0, grant_o=0, busy_o=0, tx_start_o=0, tx_data_o=8'hFF, req_ready_o=0, pkt_cnt_o=0, last_r=0.
REQ-034 Reset mid-packet SHALL abandon the packet without a tx_start_o pulse and without counting it.
REQ-035 An accepted byte SHALL NOT be replayed after reset.

Verification
REQ-036 Single packet: requester 2 sends 8'h41, 8'h42 (last) with HDR_EN=1 -> tx_data_o sequence F2, 41, 42; three tx_start_o pulses; pkt_cnt_o=1; rr_ptr=3.
REQ-037 Round-robin: all four requesters valid with 1-byte packets from reset -> grants 0,1,2,3,0.
REQ-038 Stall: requester 1 drops valid for 10 cycles mid-packet while requester 0 is valid -> grant_o stays 1; no tx_start_o during the gap.
REQ-039 Early done: tx_done_i high in the same cycle as tx_start_o -> ignored; FSM stays in WAIT until the next tx_done_i.
REQ-040 Reset mid-packet: rst_i during WAIT of byte 2 -> all outputs at reset values the next cycle; the next packet from requester 3 is granted with a header of F3.
REQ-041 Wrap: preload pkt_cnt_o near FFFF via 2 packets after a forced value or a long run -> FFFF then 0000; HDR_EN=0 sends no header byte.
